// File: rtl/galaxian_pkg.sv
// Shared types and constants for the alien formation march and dive logic.
`timescale 1ns/1ps
package galaxian_pkg;

  typedef enum logic [1:0] {
    CTRL_HOLD       = 2'b00,
    CTRL_MARCH_SLOW = 2'b01,
    CTRL_MARCH_FAST = 2'b10,
    CTRL_FREEZE     = 2'b11
  } alien_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVE   = 2'd1,
    S_RETURN = 2'd2
  } dive_state_e;

  localparam logic [9:0] X_MIN          = 10'd64;
  localparam logic [9:0] X_MAX          = 10'd320;
  localparam logic [9:0] Y_DROP         = 10'd8;
  localparam logic [9:0] Y_MAX          = 10'd200;
  localparam logic [9:0] DIVE_FLOOR     = 10'd440;
  localparam logic [9:0] X_RESET        = 10'd192;
  localparam logic [9:0] Y_RESET        = 10'd40;
  localparam logic [9:0] STEP_SLOW      = 10'd1;
  localparam logic [9:0] STEP_FAST      = 10'd2;
  localparam logic [9:0] DIVE_DOWN_STEP = 10'd3;
  localparam logic [9:0] DIVE_UP_STEP   = 10'd4;
  localparam logic [3:0] CT_ABORT       = 4'd12;
  localparam logic [3:0] LAST_ALIEN     = 4'd11;

endpackage

// File: rtl/alien_dive_fsm.sv
// Dive sequencer: one alien leaves the formation, drops to the floor and climbs back.
//   state    | meaning
//   S_IDLE   | no alien diving; dive_y parked at last formation row
//   S_DIVE   | alien descending 3 px per frame until the floor
//   S_RETURN | alien climbing 4 px per frame back to the formation
`timescale 1ns/1ps
module alien_dive_fsm
  import galaxian_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       abort,
  input  logic       launch,
  input  logic [9:0] target_y,
  output logic       dive_active,
  output logic [3:0] dive_alien,
  output logic [9:0] dive_y
);

  dive_state_e state, state_next;
  logic [9:0]  dy_next;
  logic [3:0]  alien_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      dive_y     <= Y_RESET;
      dive_alien <= 4'd0;
    end else if (frame_tick) begin
      state      <= state_next;
      dive_y     <= dy_next;
      dive_alien <= alien_next;
    end
  end

  // target_y is the formation row after this frame's update, so the alien
  // launches from and lands on the row the formation will occupy.
  always_comb begin
    state_next = state;
    dy_next    = dive_y;
    alien_next = dive_alien;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            state_next = S_DIVE;
            dy_next    = target_y;
          end
        end
        S_DIVE: begin
          dy_next = dive_y + DIVE_DOWN_STEP;
          if (dy_next >= DIVE_FLOOR) state_next = S_RETURN;
        end
        S_RETURN: begin
          if (dive_y <= target_y + DIVE_UP_STEP) begin
            state_next = S_IDLE;
            dy_next    = target_y;
            alien_next = (dive_alien == LAST_ALIEN) ? 4'd0 : dive_alien + 4'd1;
          end else begin
            dy_next = dive_y - DIVE_UP_STEP;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign dive_active = (state != S_IDLE);

endmodule

// File: rtl/alien_formation_motion.sv
// Formation march (X bounce with row drop), frame counter and dive launch.
`timescale 1ns/1ps
module alien_formation_motion
  import galaxian_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [1:0] alien_control,
  input  logic [3:0] CT,
  output logic [9:0] formation_x,
  output logic [9:0] formation_y,
  output logic       march_dir,
  output logic       dive_active,
  output logic [3:0] dive_alien,
  output logic [9:0] dive_y
);

  alien_ctrl_e ctrl;
  logic        abort, marching, wrap, dir_next;
  logic [9:0]  step, x_next, y_next, y_dropped;
  logic [5:0]  frame_cnt;

  assign ctrl = alien_ctrl_e'(alien_control);

  always_comb begin
    abort     = (ctrl == CTRL_FREEZE) || (CT >= CT_ABORT);
    marching  = !abort && (ctrl == CTRL_MARCH_SLOW || ctrl == CTRL_MARCH_FAST);
    step      = (ctrl == CTRL_MARCH_FAST) ? STEP_FAST : STEP_SLOW;
    y_dropped = (formation_y > Y_MAX - Y_DROP) ? Y_MAX : formation_y + Y_DROP;
    x_next    = formation_x;
    y_next    = formation_y;
    dir_next  = march_dir;
    if (marching) begin
      if (!march_dir) begin
        if (formation_x + step > X_MAX) begin
          x_next   = X_MAX;
          dir_next = 1'b1;
          y_next   = y_dropped;
        end else begin
          x_next = formation_x + step;
        end
      end else begin
        if (formation_x < X_MIN + step) begin
          x_next   = X_MIN;
          dir_next = 1'b0;
          y_next   = y_dropped;
        end else begin
          x_next = formation_x - step;
        end
      end
    end
    wrap = marching && (frame_cnt == 6'd63);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      formation_x <= X_RESET;
      formation_y <= Y_RESET;
      march_dir   <= 1'b0;
      frame_cnt   <= 6'd0;
    end else if (frame_tick) begin
      formation_x <= x_next;
      formation_y <= y_next;
      march_dir   <= dir_next;
      if (marching) frame_cnt <= frame_cnt + 6'd1;
    end
  end

  alien_dive_fsm u_dive (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .abort       (abort),
    .launch      (wrap),
    .target_y    (y_next),
    .dive_active (dive_active),
    .dive_alien  (dive_alien),
    .dive_y      (dive_y)
  );

endmodule

// File: tb/tb_alien_formation_motion.sv
// Self-checking bench: vector table, corner-case sequences and a randomized run against a frame-level model.
`timescale 1ns/1ps
module tb_alien_formation_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] alien_control = 2'b00;
  logic [3:0] CT = 4'd0;
  logic [9:0] formation_x, formation_y, dive_y;
  logic       march_dir, dive_active;
  logic [3:0] dive_alien;

  int errors = 0;
  int checks = 0;

  alien_formation_motion dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .alien_control (alien_control),
    .CT            (CT),
    .formation_x   (formation_x),
    .formation_y   (formation_y),
    .march_dir     (march_dir),
    .dive_active   (dive_active),
    .dive_alien    (dive_alien),
    .dive_y        (dive_y)
  );

  always #5 Clk = ~Clk;

  // Frame-level reference model: phase 0 = parked, 1 = falling, 2 = climbing.
  int m_x, m_y, m_dir, m_frames, m_phase, m_alien, m_dy;

  task automatic model_reset();
    m_x = 192; m_y = 40; m_dir = 0; m_frames = 0;
    m_phase = 0; m_alien = 0; m_dy = 40;
  endtask

  task automatic model_tick(input int c, input int t);
    bit stop, moving, launch;
    int spd, pos, ny;
    stop   = (c == 3) || (t >= 12);
    moving = !stop && (c == 1 || c == 2);
    ny     = m_y;
    launch = 0;
    if (moving) begin
      spd = c;
      pos = (m_dir == 0) ? m_x + spd : m_x - spd;
      if (pos > 320 || pos < 64) begin
        m_x   = (pos > 320) ? 320 : 64;
        m_dir = 1 - m_dir;
        ny    = (m_y + 8 > 200) ? 200 : m_y + 8;
      end else begin
        m_x = pos;
      end
      m_frames = m_frames + 1;
      launch   = (m_frames % 64 == 0);
    end
    if (stop) m_phase = 0;
    else if (m_phase == 0) begin
      if (launch) begin m_phase = 1; m_dy = ny; end
    end else if (m_phase == 1) begin
      m_dy = m_dy + 3;
      if (m_dy >= 440) m_phase = 2;
    end else begin
      if (m_dy - 4 <= ny) begin
        m_dy = ny; m_phase = 0; m_alien = (m_alien + 1) % 12;
      end else m_dy = m_dy - 4;
    end
    m_y = ny;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"},      formation_x, m_x);
    check({tag, ".y"},      formation_y, m_y);
    check({tag, ".dir"},    march_dir,   m_dir);
    check({tag, ".active"}, dive_active, (m_phase != 0) ? 1 : 0);
    check({tag, ".alien"},  dive_alien,  m_alien);
    check({tag, ".dive_y"}, dive_y,      m_dy);
  endtask

  // Called at a negative edge; returns at the next negative edge.
  task automatic do_tick(input logic [1:0] c, input logic [3:0] t);
    alien_control = c; CT = t; frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    model_tick(int'(c), int'(t));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] ctrl;
    logic [3:0] ct;
    int ticks;
    int exp_x, exp_y, exp_dir, exp_active;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saved_x, budget;
    vecs[0] = '{2'b01, 4'd0,  10, 202, 40, 0, 0};
    vecs[1] = '{2'b00, 4'd0,   5, 202, 40, 0, 0};
    vecs[2] = '{2'b10, 4'd3,   3, 208, 40, 0, 0};
    vecs[3] = '{2'b11, 4'd0,   4, 208, 40, 0, 0};
    vecs[4] = '{2'b01, 4'd12,  5, 208, 40, 0, 0};
    vecs[5] = '{2'b01, 4'd11,  2, 210, 40, 0, 0};

    do_reset();
    check("rst.x", formation_x, 192);
    check("rst.y", formation_y, 40);
    check("rst.dir", march_dir, 0);
    check("rst.active", dive_active, 0);
    check("rst.alien", dive_alien, 0);
    check("rst.dive_y", dive_y, 40);

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].ticks; k++) do_tick(vecs[v].ctrl, vecs[v].ct);
      check($sformatf("vec%0d.x", v), formation_x, vecs[v].exp_x);
      check($sformatf("vec%0d.y", v), formation_y, vecs[v].exp_y);
      check($sformatf("vec%0d.dir", v), march_dir, vecs[v].exp_dir);
      check($sformatf("vec%0d.active", v), dive_active, vecs[v].exp_active);
    end

    // No frame_tick: outputs must hold whatever the control inputs do.
    alien_control = 2'b10; CT = 4'd0;
    repeat (6) @(negedge Clk);
    check("hold.x", formation_x, 210);

    // Right bound: reach 319, then one fast step overshoots and reverses.
    do_reset();
    repeat (127) do_tick(2'b01, 4'd0);
    check("pre_bound.x", formation_x, 319);
    do_tick(2'b10, 4'd0);
    check("bound.x", formation_x, 320);
    check("bound.dir", march_dir, 1);
    check("bound.y", formation_y, 48);

    // Full dive cycle.
    do_reset();
    repeat (64) do_tick(2'b01, 4'd0);
    check("launch.active", dive_active, 1);
    check("launch.dive_y", dive_y, 40);
    budget = 0;
    while (dive_active && budget < 500) begin
      do_tick(2'b01, 4'd0);
      check_model("dive");
      budget++;
    end
    check("dive.timeout", (budget < 500) ? 1 : 0, 1);
    check("dive.done_alien", dive_alien, 1);
    check("dive.done_y", dive_y, formation_y == m_y ? m_y : -1);

    // Freeze mid-dive.
    do_reset();
    repeat (70) do_tick(2'b01, 4'd0);
    saved_x = m_x;
    do_tick(2'b11, 4'd0);
    check("freeze.active", dive_active, 0);
    check("freeze.alien", dive_alien, 0);
    check("freeze.x", formation_x, saved_x);
    repeat (2) do_tick(2'b11, 4'd0);
    check("freeze.x_held", formation_x, saved_x);

    // All aliens hit: fast march stalls.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_tick(2'b10, 4'd12);
      check($sformatf("ct12.x%0d", k), formation_x, 192);
    end

    // Asynchronous reset mid-dive, checked before any rising edge.
    do_reset();
    repeat (80) do_tick(2'b10, 4'd0);
    check_model("pre_async");
    Reset = 1'b1;
    #2;
    check("async.x", formation_x, 192);
    check("async.y", formation_y, 40);
    check("async.dir", march_dir, 0);
    check("async.active", dive_active, 0);
    check("async.alien", dive_alien, 0);
    check("async.dive_y", dive_y, 40);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    repeat (64) do_tick(2'b01, 4'd0);
    check("post_async.launch", dive_active, 1);

    // Randomized run against the model; early part rarely aborts so dives finish.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int r, gap, abort_pct;
      logic [1:0] c;
      logic [3:0] t;
      abort_pct = (n < 1200) ? 1 : 12;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        alien_control = 2'($urandom);
        CT = 4'($urandom);
        @(negedge Clk);
      end
      if (gap != 0) check_model("rnd_gap");
      r = $urandom_range(0, 99);
      if (r < abort_pct) c = 2'b11;
      else if (r < abort_pct + 5) c = 2'b00;
      else c = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      t = ($urandom_range(0, 99) < abort_pct) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      do_tick(c, t);
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alien_formation_motion.md
ALIEN_FORMATION_MOTION -- requirements
Module: alien_formation_motion

Interface
REQ-001 SHALL have port Clk, input, 1 bit: system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port frame_tick, input, 1 bit: single-Clk-cycle pulse, once per video frame; this is the only update enable.
REQ-004 SHALL have port alien_control, input, 2 bits: game state from the control unit (encoding in REQ-010).
REQ-005 SHALL have port CT, input, 4 bits: aliens-hit count from the control unit (0..12).
REQ-006 SHALL have port formation_x, output, 10 bits: formation left-edge X in pixels.
REQ-007 SHALL have port formation_y, output, 10 bits: formation top-edge Y in pixels.
REQ-008 SHALL have port march_dir, output, 1 bit: 0 = moving right, 1 = moving left.
REQ-009 SHALL have ports dive_active (1 bit), dive_alien (4 bits, index 0..11) and dive_y (10 bits), all outputs: diving-alien status, index and Y position.

Function
REQ-010 alien_control encoding SHALL be: 00 HOLD, 01 MARCH_SLOW, 10 MARCH_FAST, 11 FREEZE.
REQ-011 All outputs SHALL be registered and SHALL change only in the cycle after a sampled frame_tick (1-cycle latency); with no frame_tick, all outputs SHALL hold.
REQ-012 X step per tick SHALL be 1 px in MARCH_SLOW, 2 px in MARCH_FAST, and 0 in HOLD and FREEZE.
REQ-013 X bounds SHALL be X_MIN = 64 and X_MAX = 320.
REQ-014 Bound handling: if the next X would cross a bound, formation_x SHALL clamp to that bound, march_dir SHALL invert, and formation_y SHALL increase by Y_DROP = 8, all in the same update.
REQ-015 formation_y SHALL saturate at Y_MAX = 200; once saturated, no further drop SHALL occur.
REQ-016 Dive FSM SHALL have three states: IDLE, DIVE, RETURN.
REQ-017 A 6-bit frame counter SHALL increment on each tick while in MARCH_SLOW or MARCH_FAST and SHALL wrap from 63 to 0.
REQ-018 IDLE -> DIVE SHALL occur on the tick where the counter wraps to 0, provided the state is MARCH_*; on this transition dive_y SHALL load formation_y and dive_active SHALL be set to 1.
REQ-019 In DIVE, dive_y SHALL increase by 3 px per tick; when dive_y >= 440 (DIVE_FLOOR), the FSM SHALL go to RETURN.
REQ-020 In RETURN, dive_y SHALL decrease by 4 px per tick.
REQ-021 RETURN -> IDLE: when dive_y - 4 <= formation_y, dive_y SHALL be set to formation_y, dive_active SHALL clear, and dive_alien SHALL advance by 1 (11 wraps to 0).
REQ-022 Abort rule: in FREEZE, or when CT >= 12, on the next tick the dive FSM SHALL go to IDLE, dive_active SHALL clear, and X/Y motion SHALL stop; dive_alien SHALL not advance.
REQ-023 HOLD SHALL stop X/Y motion and the frame counter, but an in-progress dive SHALL complete.
REQ-024 Priority SHALL be: abort > bound reversal > normal step.

Reset
REQ-025 Reset SHALL asynchronously force the outputs to: formation_x = 192, formation_y = 40, march_dir = 0, dive_active = 0, dive_alien = 0, dive_y = 40.
REQ-026 Reset SHALL also force the frame counter to 0 and the dive FSM to IDLE, including when asserted mid-dive.

Structure
REQ-027 A shared package (galaxian_pkg) SHALL hold the alien_control enum, X_MIN, X_MAX, Y_DROP, Y_MAX, DIVE_FLOOR, the step sizes and the dive FSM state typedef.
REQ-028 Dive logic SHALL be a sub-module named alien_dive_fsm; the top module SHALL own the march logic and the frame counter.

Verification
REQ-029 After reset, apply MARCH_SLOW for 10 ticks -> formation_x = 202, march_dir = 0, formation_y = 40.
REQ-030 Start at formation_x = 319 in MARCH_FAST, moving right, apply 1 tick -> formation_x = 320, march_dir = 1, formation_y = 48.
REQ-031 In MARCH_SLOW, apply 64 ticks -> dive_active = 1 and dive_y = formation_y; continue until dive_y >= 440, then it returns -> dive_active = 0 and dive_alien = 1.
REQ-032 Mid-dive, set alien_control = 11 -> after 1 tick dive_active = 0, dive_alien is unchanged, and formation_x is frozen.
REQ-033 Set CT = 12 in MARCH_FAST -> formation_x is constant across 5 ticks.
REQ-034 Assert Reset between ticks mid-dive -> all outputs take their REQ-025 values immediately, with no Clk edge required.
